// File: rtl/bp_mem_concentrator_rr.sv
// N-to-1 wormhole command concentrator with round-robin packet arbitration,
// plus a cid-steered response demux that drops packets addressed to absent channels.
module bp_mem_concentrator_rr #(
  parameter int flit_width_p = 64,
  parameter int len_width_p  = 4,
  parameter int cid_width_p  = 3,
  parameter int cord_width_p = 8,
  parameter int num_in_p     = 4,
  parameter int fifo_els_p   = 2
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_in_p*flit_width_p-1:0] cmd_data_i,
  input  logic [num_in_p-1:0]              cmd_v_i,
  output logic [num_in_p-1:0]              cmd_ready_and_o,
  output logic [flit_width_p-1:0]          conc_cmd_data_o,
  output logic                             conc_cmd_v_o,
  input  logic                             conc_cmd_ready_and_i,
  input  logic [flit_width_p-1:0]          conc_resp_data_i,
  input  logic                             conc_resp_v_i,
  output logic                             conc_resp_ready_and_o,
  output logic [num_in_p*flit_width_p-1:0] resp_data_o,
  output logic [num_in_p-1:0]              resp_v_o,
  input  logic [num_in_p-1:0]              resp_ready_and_i,
  output logic                             bad_cid_o
);

  localparam int idx_w_lp   = (num_in_p > 1) ? $clog2(num_in_p) : 1;
  localparam int ptr_w_lp   = $clog2(fifo_els_p);
  localparam int cnt_w_lp   = $clog2(fifo_els_p + 1);
  localparam int len_lsb_lp = cord_width_p;
  localparam int cid_lsb_lp = cord_width_p + len_width_p;

  logic [flit_width_p-1:0] head_data [num_in_p];
  logic [num_in_p-1:0]     head_v;
  logic [num_in_p-1:0]     deq;

  for (genvar g = 0; g < num_in_p; g++) begin : g_fifo
    logic [flit_width_p-1:0] mem_q [fifo_els_p];
    logic [ptr_w_lp-1:0]     rptr_q, wptr_q;
    logic [cnt_w_lp-1:0]     cnt_q;
    logic                    enq;

    assign cmd_ready_and_o[g] = reset_n_i & (cnt_q != cnt_w_lp'(fifo_els_p));
    assign enq                = cmd_v_i[g] & cmd_ready_and_o[g];
    assign head_v[g]          = (cnt_q != '0);
    assign head_data[g]       = mem_q[rptr_q];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        rptr_q <= '0;
        wptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (enq)
          wptr_q <= (wptr_q == ptr_w_lp'(fifo_els_p - 1)) ? '0 : wptr_q + 1'b1;
        if (deq[g])
          rptr_q <= (rptr_q == ptr_w_lp'(fifo_els_p - 1)) ? '0 : rptr_q + 1'b1;
        if (enq && !deq[g])
          cnt_q <= cnt_q + 1'b1;
        else if (!enq && deq[g])
          cnt_q <= cnt_q - 1'b1;
      end
    end

    // Storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk_i) begin
      if (enq)
        mem_q[wptr_q] <= cmd_data_i[g*flit_width_p +: flit_width_p];
    end
  end

  typedef enum logic {CMD_IDLE, CMD_LOCKED} cmd_state_e;

  cmd_state_e              cmd_state_q, cmd_state_d;
  logic [idx_w_lp-1:0]     gnt_q, gnt_d, rr_q, rr_d;
  logic [idx_w_lp-1:0]     sel_idx, cand, cur_gnt;
  logic [len_width_p-1:0]  cmd_cnt_q, cmd_cnt_d, cmd_len;
  logic                    hold_q, hold_d, sel_found, cmd_fire;

  // Scan downward from the farthest candidate so the one nearest rr_q wins.
  always_comb begin : rr_pick
    sel_found = 1'b0;
    sel_idx   = rr_q;
    cand      = rr_q;
    for (int k = num_in_p - 1; k >= 0; k--) begin
      cand = idx_w_lp'((int'(rr_q) + k) % num_in_p);
      if (head_v[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cmd_state_q <= CMD_IDLE;
      gnt_q       <= '0;
      rr_q        <= '0;
      cmd_cnt_q   <= '0;
      hold_q      <= 1'b0;
    end else begin
      cmd_state_q <= cmd_state_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      cmd_cnt_q   <= cmd_cnt_d;
      hold_q      <= hold_d;
    end
  end

  // hold_q pins a stalled header's grant so a newly valid channel cannot steal it.
  always_comb begin : cmd_out
    cur_gnt      = sel_idx;
    conc_cmd_v_o = sel_found;
    if (cmd_state_q == CMD_LOCKED || hold_q) begin
      cur_gnt      = gnt_q;
      conc_cmd_v_o = head_v[gnt_q];
    end
    conc_cmd_data_o = head_data[cur_gnt];
    deq             = '0;
    deq[cur_gnt]    = conc_cmd_v_o & conc_cmd_ready_and_i;
  end

  assign cmd_fire = conc_cmd_v_o & conc_cmd_ready_and_i;
  assign cmd_len  = conc_cmd_data_o[len_lsb_lp +: len_width_p];

  always_comb begin : cmd_next
    cmd_state_d = cmd_state_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    cmd_cnt_d   = cmd_cnt_q;
    hold_d      = hold_q;
    case (cmd_state_q)
      CMD_IDLE: begin
        if (cmd_fire) begin
          hold_d = 1'b0;
          rr_d   = (cur_gnt == idx_w_lp'(num_in_p - 1)) ? '0 : cur_gnt + 1'b1;
          if (cmd_len != '0) begin
            cmd_state_d = CMD_LOCKED;
            gnt_d       = cur_gnt;
            cmd_cnt_d   = cmd_len;
          end
        end else if (conc_cmd_v_o) begin
          hold_d = 1'b1;
          gnt_d  = cur_gnt;
        end
      end
      CMD_LOCKED: begin
        if (cmd_fire) begin
          cmd_cnt_d = cmd_cnt_q - 1'b1;
          if (cmd_cnt_q == len_width_p'(1))
            cmd_state_d = CMD_IDLE;
        end
      end
      default: cmd_state_d = CMD_IDLE;
    endcase
  end

  typedef enum logic [1:0] {RESP_IDLE, RESP_FWD, RESP_DROP} resp_state_e;

  resp_state_e             resp_state_q, resp_state_d;
  logic [cid_width_p-1:0]  tgt_q, tgt_d, resp_cid;
  logic [len_width_p-1:0]  resp_cnt_q, resp_cnt_d, resp_len;
  logic                    bad_q, bad_d, cid_ok, resp_fire;

  assign resp_cid    = conc_resp_data_i[cid_lsb_lp +: cid_width_p];
  assign resp_len    = conc_resp_data_i[len_lsb_lp +: len_width_p];
  assign cid_ok      = ({1'b0, resp_cid} < (cid_width_p + 1)'(num_in_p));
  assign resp_fire   = conc_resp_v_i & conc_resp_ready_and_o;
  assign resp_data_o = {num_in_p{conc_resp_data_i}};
  assign bad_cid_o   = bad_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_state_q <= RESP_IDLE;
      tgt_q        <= '0;
      resp_cnt_q   <= '0;
      bad_q        <= 1'b0;
    end else begin
      resp_state_q <= resp_state_d;
      tgt_q        <= tgt_d;
      resp_cnt_q   <= resp_cnt_d;
      bad_q        <= bad_d;
    end
  end

  always_comb begin : resp_next
    resp_state_d = resp_state_q;
    tgt_d        = tgt_q;
    resp_cnt_d   = resp_cnt_q;
    bad_d        = bad_q;
    case (resp_state_q)
      RESP_IDLE: begin
        if (resp_fire) begin
          if (!cid_ok)
            bad_d = 1'b1;
          if (resp_len != '0) begin
            resp_cnt_d   = resp_len;
            tgt_d        = resp_cid;
            resp_state_d = cid_ok ? RESP_FWD : RESP_DROP;
          end
        end
      end
      RESP_FWD, RESP_DROP: begin
        if (resp_fire) begin
          resp_cnt_d = resp_cnt_q - 1'b1;
          if (resp_cnt_q == len_width_p'(1))
            resp_state_d = RESP_IDLE;
        end
      end
      default: resp_state_d = RESP_IDLE;
    endcase
  end

  always_comb begin : resp_out
    resp_v_o              = '0;
    conc_resp_ready_and_o = 1'b0;
    for (int i = 0; i < num_in_p; i++) begin
      if ((resp_state_q == RESP_IDLE && resp_cid == cid_width_p'(i)) ||
          (resp_state_q == RESP_FWD  && tgt_q    == cid_width_p'(i))) begin
        resp_v_o[i]           = conc_resp_v_i;
        conc_resp_ready_and_o = resp_ready_and_i[i];
      end
    end
    if (resp_state_q == RESP_DROP || (resp_state_q == RESP_IDLE && !cid_ok))
      conc_resp_ready_and_o = 1'b1;
    if (!reset_n_i) begin
      resp_v_o              = '0;
      conc_resp_ready_and_o = 1'b0;
    end
  end

endmodule
